// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit and the latches it drives.
package pipe_ctrl_pkg;

    localparam logic [1:0] CTR_NORMAL = 2'b00;
    localparam logic [1:0] CTR_SQUASH = 2'b01;
    localparam logic [1:0] CTR_STALL  = 2'b10;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        MC  = 1'b1
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic [1:0] memwb;
    } ctl_t;

    function automatic ctl_t ctl_pattern(input logic       pc_en,
                                         input logic [1:0] ifid,
                                         input logic [1:0] idex,
                                         input logic [1:0] exmem,
                                         input logic [1:0] memwb);
        ctl_t c;
        c.pc_en = pc_en;
        c.ifid  = ifid;
        c.idex  = idex;
        c.exmem = exmem;
        c.memwb = memwb;
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hazard
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = ex_is_load && (ex_rd != {REG_W{1'b0}}) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: latch control codes, PC enable, multi-cycle EX sequencing
// and a stall-cycle performance counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int REG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_mc_start,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic [1:0]       ifid_ctr,
    output logic [1:0]       idex_ctr,
    output logic [1:0]       exmem_ctr,
    output logic [1:0]       memwb_ctr,
    output logic             mc_done,
    output logic [31:0]      stall_cnt
);

    localparam int              CNT_W    = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic load_use_s;
    logic mc_hold_s;
    logic mc_exit_s;
    logic mc_start_s;
    ctl_t ctl_s;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .hazard     (load_use_s)
    );

    // Priority mux, FSM next state and counter updates.
    always_comb begin
        mc_hold_s  = (state_q == MC) && (cnt_q != {CNT_W{1'b0}});
        mc_exit_s  = (state_q == MC) && (cnt_q == {CNT_W{1'b0}});
        // EX is still held on the exit cycle, so its start flag must not relaunch the op.
        mc_start_s = ex_mc_start && !mc_exit_s;

        state_d = state_q;
        cnt_d   = cnt_q;

        if (mem_busy) begin
            ctl_s = ctl_pattern(1'b0, CTR_STALL, CTR_STALL, CTR_STALL, CTR_SQUASH);
        end else if (mc_hold_s || mc_start_s) begin
            ctl_s = ctl_pattern(1'b0, CTR_STALL, CTR_STALL, CTR_SQUASH, CTR_NORMAL);
        end else if (ex_redirect) begin
            ctl_s = ctl_pattern(1'b1, CTR_SQUASH, CTR_SQUASH, CTR_NORMAL, CTR_NORMAL);
        end else if (load_use_s) begin
            ctl_s = ctl_pattern(1'b0, CTR_STALL, CTR_SQUASH, CTR_NORMAL, CTR_NORMAL);
        end else begin
            ctl_s = ctl_pattern(1'b1, CTR_NORMAL, CTR_NORMAL, CTR_NORMAL, CTR_NORMAL);
        end

        if (mc_hold_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (mc_exit_s) begin
            state_d = mem_busy ? MC : RUN;
        end else if (!mem_busy && mc_start_s) begin
            state_d = MC;
            cnt_d   = CNT_LOAD;
        end else begin
            state_d = RUN;
        end

        if (rst) begin
            pc_en     = 1'b0;
            ifid_ctr  = CTR_NORMAL;
            idex_ctr  = CTR_NORMAL;
            exmem_ctr = CTR_NORMAL;
            memwb_ctr = CTR_NORMAL;
            mc_done   = 1'b0;
        end else begin
            pc_en     = ctl_s.pc_en;
            ifid_ctr  = ctl_s.ifid;
            idex_ctr  = ctl_s.idex;
            exmem_ctr = ctl_s.exmem;
            memwb_ctr = ctl_s.memwb;
            mc_done   = mc_exit_s;
        end

        stall_cnt_d = pc_en ? stall_cnt_q : (stall_cnt_q + 32'd1);
        stall_cnt   = stall_cnt_q;
    end

    // State, counter and performance-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= {CNT_W{1'b0}};
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MC_LAT = 4;
    localparam int REG_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, ex_mc_start, mem_busy;
    logic             pc_en, mc_done;
    logic [1:0]       ifid_ctr, idex_ctr, exmem_ctr, memwb_ctr;
    logic [31:0]      stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: remaining EX occupancy of a multi-cycle op (0 = none, 1 = result cycle).
    int          occ_left = 0;
    logic [31:0] m_stall  = 32'd0;
    logic        e_pc, e_done;
    logic [1:0]  e_ifid, e_idex, e_exmem, e_memwb;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .REG_W(REG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .ex_mc_start (ex_mc_start),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_ctr    (ifid_ctr),
        .idex_ctr    (idex_ctr),
        .exmem_ctr   (exmem_ctr),
        .memwb_ctr   (memwb_ctr),
        .mc_done     (mc_done),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_pat(input logic p, input logic [1:0] a, b, c, d);
        e_pc = p; e_ifid = a; e_idex = b; e_exmem = c; e_memwb = d;
    endtask

    task automatic model_outputs();
        bit lu;
        lu = ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_done = 1'b0;
        if (rst)                                  set_pat(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        else begin
            e_done = (occ_left == 1);
            if (mem_busy)                         set_pat(1'b0, 2'b10, 2'b10, 2'b10, 2'b01);
            else if (occ_left > 1)                set_pat(1'b0, 2'b10, 2'b10, 2'b01, 2'b00);
            else if (ex_mc_start && occ_left == 0) set_pat(1'b0, 2'b10, 2'b10, 2'b01, 2'b00);
            else if (ex_redirect)                 set_pat(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
            else if (lu)                          set_pat(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
            else                                  set_pat(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            occ_left = 0;
            m_stall  = 32'd0;
        end else begin
            if (!e_pc) m_stall = m_stall + 32'd1;
            if (occ_left > 1)                              occ_left = occ_left - 1;
            else if (occ_left == 1)                        occ_left = mem_busy ? 1 : 0;
            else if (ex_mc_start && !mem_busy)             occ_left = MC_LAT - 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit chk, input string tag);
        #2;
        model_outputs();
        if (chk) begin
            check({tag, ".pc_en"},     {31'd0, pc_en},     {31'd0, e_pc});
            check({tag, ".ifid"},      {30'd0, ifid_ctr},  {30'd0, e_ifid});
            check({tag, ".idex"},      {30'd0, idex_ctr},  {30'd0, e_idex});
            check({tag, ".exmem"},     {30'd0, exmem_ctr}, {30'd0, e_exmem});
            check({tag, ".memwb"},     {30'd0, memwb_ctr}, {30'd0, e_memwb});
            check({tag, ".mc_done"},   {31'd0, mc_done},   {31'd0, e_done});
            check({tag, ".stall_cnt"}, stall_cnt,          m_stall);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; ex_mc_start = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        logic [31:0] s0;
        idle();
        rst = 1'b1;
        @(posedge clk); model_edge(); #1;
        cycle(1'b1, "reset");

        // Load-use, then the same with x0 as the load target.
        idle(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cycle(1'b1, "load_use");
        ex_rd = 5'd0; id_rs1 = 5'd0;
        cycle(1'b1, "load_x0");

        idle(); ex_redirect = 1'b1;
        cycle(1'b1, "redirect");

        // Multi-cycle op with start held: three stall cycles then the result cycle.
        idle(); ex_mc_start = 1'b1; s0 = stall_cnt;
        for (int i = 0; i < MC_LAT; i++) cycle(1'b1, "mc_seq");
        check("mc_stall_delta", stall_cnt - s0, 32'(MC_LAT - 1));
        idle();
        cycle(1'b1, "mc_after");

        // Data-cache miss arriving on the result cycle holds the FSM in MC.
        ex_mc_start = 1'b1;
        for (int i = 0; i < MC_LAT - 1; i++) cycle(1'b1, "mcx_pre");
        mem_busy = 1'b1;
        cycle(1'b1, "mcx_busy0");
        cycle(1'b1, "mcx_busy1");
        mem_busy = 1'b0;
        cycle(1'b1, "mcx_done");
        idle();
        cycle(1'b1, "mcx_run");

        // Priority: miss beats redirect and load-use; redirect follows once the miss clears.
        ex_redirect = 1'b1; mem_busy = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle(1'b1, "prio_busy");
        mem_busy = 1'b0;
        cycle(1'b1, "prio_redirect");

        // Reset while the multi-cycle counter is at 1.
        idle(); ex_mc_start = 1'b1;
        cycle(1'b1, "rstmc_start");
        cycle(1'b1, "rstmc_cnt2");
        rst = 1'b1;
        cycle(1'b1, "rstmc_rst");
        idle();
        cycle(1'b1, "rstmc_run");

        // Counter wrap from all ones.
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFF;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        cycle(1'b1, "wrap_stall");
        idle();
        cycle(1'b1, "wrap_zero");
        check("wrap_value", stall_cnt, 32'd0);

        // Randomized traffic with small register indices to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            mem_busy    = ($urandom_range(0, 3) == 0);
            ex_redirect = ($urandom_range(0, 4) == 0);
            ex_mc_start = (occ_left > 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
            ex_is_load  = ($urandom_range(0, 1) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = ($urandom_range(0, 1) == 0);
            id_use_rs2  = ($urandom_range(0, 1) == 0);
            cycle(1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
